// File: rtl/vec_check_i8.sv
// vec_check_i8: LFSR-driven stimulus sequencer and response checker for an 8-bit adder DUT
module vec_check_i8 #(
  parameter int          LATENCY = 1,
  parameter logic [15:0] SEED    = 16'h0309
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] num_vectors,
  output logic [7:0]  a,
  output logic [7:0]  b,
  input  logic [7:0]  y,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [15:0] err_index,
  output logic [7:0]  err_expected,
  output logic [7:0]  err_actual
);
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, PASS, FAIL} state_t;
  localparam int D = (LATENCY == 0) ? 1 : LATENCY;
  state_t      state, state_nx;
  logic [15:0] lfsr, n, issued, checked;
  logic [7:0]  exp_line [D];
  logic [D-1:0] vld_line;
  logic [7:0]  sum, cmp_e;
  logic        cmp_v, accept, mism, fin;
  function automatic logic [15:0] step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction
  assign busy = state == RUN || state == DRAIN;
  assign done = state == PASS || state == FAIL;
  assign pass = state == PASS;
  assign fail = state == FAIL;
  assign sum  = a + b;
  // With zero latency the expected value is compared in the same cycle it is issued
  always_comb begin
    cmp_v  = (LATENCY == 0) ? state == RUN : busy && vld_line[D-1];
    cmp_e  = (LATENCY == 0) ? sum : exp_line[D-1];
    accept = start && !busy;
    mism   = cmp_v && cmp_e != y;
    fin    = cmp_v && !mism && checked == n - 16'd1;
    state_nx = state;
    if (accept) state_nx = (num_vectors == 16'd0) ? PASS : RUN;
    else if (busy) state_nx = mism ? FAIL : fin ? PASS : (state == RUN && issued == n) ? DRAIN : state;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state        <= IDLE;
      a            <= '0;
      b            <= '0;
      lfsr         <= SEED;
      n            <= '0;
      issued       <= '0;
      checked      <= '0;
      vld_line     <= '0;
      for (int i = 0; i < D; i++) exp_line[i] <= '0;
      err_index    <= '0;
      err_expected <= '0;
      err_actual   <= '0;
    end else begin
      state <= state_nx;
      for (int i = D - 1; i > 0; i--) begin
        exp_line[i] <= exp_line[i-1];
        vld_line[i] <= vld_line[i-1];
      end
      exp_line[0] <= sum;
      vld_line[0] <= state == RUN;
      if (accept) begin
        n            <= num_vectors;
        issued       <= 16'd1;
        checked      <= '0;
        vld_line     <= '0;
        err_index    <= '0;
        err_expected <= '0;
        err_actual   <= '0;
      end else if (cmp_v && !mism) checked <= checked + 16'd1;
      if (mism) begin
        err_index    <= checked;
        err_expected <= cmp_e;
        err_actual   <= y;
      end
      if (accept && num_vectors != 16'd0) begin
        a    <= SEED[7:0];
        b    <= SEED[15:8];
        lfsr <= step(SEED);
      end else if (state_nx == PASS || state_nx == FAIL) begin
        a <= '0;
        b <= '0;
      end else if (state == RUN && issued != n) begin
        a      <= lfsr[7:0];
        b      <= lfsr[15:8];
        lfsr   <= step(lfsr);
        issued <= issued + 16'd1;
      end
    end
endmodule

// File: tb/tb_vec_check_i8.sv
// tb_vec_check_i8: drives four checker instances (latency 0/1/3, two seeds) against fault-injectable adders
module tb_vec_check_i8;
  logic        clock, reset;
  logic [15:0] nv;
  logic [3:0]  start, busy_v, done_v, pass_v, fail_v;
  logic [7:0]  a_v [4], b_v [4], ee_v [4], ea_v [4];
  logic [15:0] ei_v [4];
  int          bad [4];
  int          nvec, nbad;
  typedef struct {int g; int n; int bd; int poke; bit xp; string nm;} vec_t;
  vec_t tbl [10];
  initial clock = 1'b0;
  always #5 clock = ~clock;
  for (genvar g = 0; g < 4; g++) begin : gi
    localparam int L = (g == 0) ? 0 : (g == 2) ? 3 : 1;
    logic [7:0]  a_l, b_l, y_l, raw, ee, ea;
    logic [15:0] ei;
    logic        bu, dn, ps, fl;
    logic [7:0]  pipe [3];
    int          k;
    // k is the index of the vector currently on a/b; that vector's result gets bit 0 flipped when k hits bad[g]
    assign raw = (a_l + b_l) ^ ((k == bad[g]) ? 8'h01 : 8'h00);
    assign y_l = (L == 0) ? raw : pipe[(L == 0) ? 0 : L - 1];
    always @(posedge clock) begin
      pipe[0] <= raw;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
      k <= (start[g] && !bu) ? 0 : k + 1;
    end
    vec_check_i8 #(.LATENCY(L), .SEED((g == 3) ? 16'hFFFF : 16'h0309)) dut (
      .clock(clock), .reset(reset), .start(start[g]), .num_vectors(nv),
      .a(a_l), .b(b_l), .y(y_l), .busy(bu), .done(dn), .pass(ps), .fail(fl),
      .err_index(ei), .err_expected(ee), .err_actual(ea));
    assign a_v[g] = a_l;
    assign b_v[g] = b_l;
    assign ee_v[g] = ee;
    assign ea_v[g] = ea;
    assign ei_v[g] = ei;
    assign busy_v[g] = bu;
    assign done_v[g] = dn;
    assign pass_v[g] = ps;
    assign fail_v[g] = fl;
  end
  function automatic logic [15:0] lf(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction
  function automatic int lat_of(input int g);
    return (g == 0) ? 0 : (g == 2) ? 3 : 1;
  endfunction
  function automatic logic [15:0] seed_of(input int g);
    return (g == 3) ? 16'hFFFF : 16'h0309;
  endfunction
  task automatic chk(input string nm, input string f, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s.%s: got %0h, want %0h", nm, f, act, exp);
    end
  endtask
  task automatic chk_reset(input int g, input string nm);
    chk(nm, "outs", {a_v[g], b_v[g], ei_v[g], ee_v[g], ea_v[g], busy_v[g], done_v[g], pass_v[g], fail_v[g]}, 64'd0);
  endtask
  // One run: the model lists the vectors from the LFSR rule, sums them mod 256 and predicts the busy length
  task automatic run(input int g, input int n, input int bd, input int poke, input bit xp, input string nm);
    logic [15:0] v [$];
    logic [15:0] l;
    logic [7:0]  xe;
    int          cyc, nb, L, xcyc;
    bit          mp;
    L = lat_of(g);
    l = seed_of(g);
    for (int k = 0; k < n; k++) begin
      v.push_back(l);
      l = lf(l);
    end
    mp = bd < 0 || bd >= n;
    xe = 8'h00;
    if (!mp) xe = 8'((int'(v[bd][7:0]) + int'(v[bd][15:8])) % 256);
    xcyc = mp ? ((n == 0) ? 0 : n + L) : bd + L + 1;
    bad[g] = bd;
    @(negedge clock);
    nv = 16'(n);
    start[g] = 1'b1;
    @(negedge clock);
    start[g] = 1'b0;
    cyc = 0;
    nb = 0;
    while (!done_v[g] && cyc < n + L + 16) begin
      if (busy_v[g]) nb++;
      if (busy_v[g] && cyc < n) chk(nm, "ab", {a_v[g], b_v[g]}, {v[cyc][7:0], v[cyc][15:8]});
      start[g] = (cyc == poke);
      @(negedge clock);
      cyc++;
    end
    start[g] = 1'b0;
    chk(nm, "done", done_v[g], 1);
    chk(nm, "pass", pass_v[g], xp);
    chk(nm, "fail", fail_v[g], !xp);
    chk(nm, "busy", busy_v[g], 0);
    chk(nm, "busy_cycles", nb, xcyc);
    chk(nm, "ab_idle", {a_v[g], b_v[g]}, 0);
    chk(nm, "err_index", ei_v[g], mp ? 0 : bd);
    chk(nm, "err_expected", ee_v[g], xe);
    chk(nm, "err_actual", ea_v[g], mp ? 8'h00 : xe ^ 8'h01);
  endtask
  initial begin
    int g, n, bd;
    nvec = 0;
    nbad = 0;
    reset = 1'b0;
    start = '0;
    nv = '0;
    for (int i = 0; i < 4; i++) bad[i] = -1;
    tbl[0] = '{1, 1, -1, -1, 1, "n1_pass"};
    tbl[1] = '{1, 1, 0, -1, 0, "n1_y13"};
    tbl[2] = '{1, 2, -1, -1, 1, "n2_pass"};
    tbl[3] = '{3, 1, -1, -1, 1, "seed_ffff_wrap"};
    tbl[4] = '{1, 0, -1, -1, 1, "n0"};
    tbl[5] = '{2, 1000, -1, 500, 1, "lat3_n1000_poke"};
    tbl[6] = '{2, 1000, 777, -1, 0, "lat3_bad777"};
    tbl[7] = '{0, 5, -1, -1, 1, "lat0_pass"};
    tbl[8] = '{0, 5, 3, -1, 0, "lat0_bad3"};
    tbl[9] = '{1, 3, 2, -1, 0, "lat1_bad_last"};
    #12;
    for (int i = 0; i < 4; i++) chk_reset(i, "reset");
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) run(tbl[i].g, tbl[i].n, tbl[i].bd, tbl[i].poke, tbl[i].xp, tbl[i].nm);
    bad[1] = -1;
    @(negedge clock);
    nv = 16'd100;
    start[1] = 1'b1;
    @(negedge clock);
    start[1] = 1'b0;
    repeat (40) @(negedge clock);
    chk("mid_run", "busy", busy_v[1], 1);
    #2 reset = 1'b0;
    #1 chk_reset(1, "async_reset");
    @(negedge clock);
    chk_reset(1, "reset_held");
    reset = 1'b1;
    run(1, 1, -1, -1, 1, "post_reset");
    for (int r = 0; r < 8; r++) begin
      g = int'($urandom_range(0, 3));
      n = int'($urandom_range(1, 40));
      bd = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : -1;
      run(g, n, bd, -1, bd < 0, "rnd");
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
